dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_MSB, default 31, the MSB index of data words.
REQ-002 The block SHALL have parameter ADDR_MSB, default 7, the MSB index of word addresses (256 cells).
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, the cycles port 1 may lose arbitration before it is forced through.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports req0, we0 (inputs, 1 bit), addr0 (input, ADDR_MSB+1) and wdata0 (input, DATA_MSB+1): the pipeline MEM-stage request, which has priority.
REQ-007 The block SHALL have ports ack0 (output, 1 bit) and rdata0 (output, DATA_MSB+1): port-0 completion pulse and read data.
REQ-008 The block SHALL have ports req1, we1, addr1, wdata1, ack1 and rdata1, identical to port 0: the secondary requester (loader/debug).
REQ-009 The block SHALL have ports mem_address (output, ADDR_MSB+1), mem_write_data (output, DATA_MSB+1) and mem_control_write (output, 1 bit): drive to the data memory.
REQ-010 The block SHALL have port mem_read_data (input, DATA_MSB+1): combinational read data for mem_address.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and RESP, transitioning IDLE->ACCESS when any reqN=1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-012 Arbitration SHALL occur only in IDLE: grant port 1 if req1=1 and (req0=0 or wait_cnt==MAX_WAIT); otherwise grant port 0 if req0=1.
REQ-013 On grant, addr, we and wdata of the granted port SHALL be latched into mem_address, mem_write_data and a write flag, and the granted port index SHALL be registered.
REQ-014 mem_control_write SHALL be 1 exactly during ACCESS when the latched write flag is 1, and 0 in every other state.
REQ-015 In ACCESS, for a read, mem_read_data SHALL be registered into rdataN of the granted port; for a write, rdataN SHALL be unchanged.
REQ-016 In RESP, ackN of the granted port SHALL be 1 for exactly one cycle; the other ack SHALL stay 0, and both acks SHALL never be 1 together.
REQ-017 The latency from a req sampled in IDLE to ack SHALL be 2 cycles, with a maximum throughput of one transaction per 3 cycles.
REQ-018 mem_address and mem_write_data SHALL hold their last latched values outside ACCESS.
REQ-019 Requesters SHALL hold req, we, addr and wdata stable until ack; a req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-020 Deassertion of req during ACCESS or RESP SHALL be ignored, and the transaction SHALL complete with ack.
REQ-021 wait_cnt SHALL be width clog2(MAX_WAIT+1), increment in IDLE when req1=1 and port 0 is granted, saturate at MAX_WAIT, and clear when port 1 is granted or req1=0 in IDLE.
REQ-022 Simultaneous req0 and req1 with wait_cnt<MAX_WAIT SHALL grant port 0; with wait_cnt==MAX_WAIT they SHALL grant port 1.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state IDLE, ack0=ack1=0, rdata0=rdata1=0, mem_address=0, mem_write_data=0, mem_control_write=0 and wait_cnt=0.
REQ-024 Reset asserted mid-ACCESS SHALL drop mem_control_write immediately, abort the transaction, and issue no ack.
REQ-025 After reset deasserts, the first grant SHALL occur on the first rising edge with reqN=1 in IDLE.

Structure
REQ-026 The state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the port index constants SHALL be defined in shared package dmem_arb_pkg.
REQ-027 The data memory SHALL be instantiated outside this block; dmem_arbiter SHALL contain no sub-modules, since its grant logic is a single combinational expression.

Verification
REQ-028 The bench SHALL cover: req0 write addr 8'h10 data 32'hDEADBEEF, then req0 read 8'h10 -> mem_control_write high one cycle, ack0 2 cycles after each req, rdata0=32'hDEADBEEF.
REQ-029 The bench SHALL cover: req0 and req1 both reads from the same cycle -> port 0 acked first, port 1 acked 3 cycles later, and ack0/ack1 never coincide.
REQ-030 The bench SHALL cover: req0 held continuously with req1 high, MAX_WAIT=4 -> port 1 granted after exactly 4 lost arbitrations and wait_cnt returns to 0.
REQ-031 The bench SHALL cover: req1 write addr 8'hFF (top cell) data 32'h1 with req1 dropped in ACCESS -> write still occurs and ack1 pulses once.
REQ-032 The bench SHALL cover: reset_n pulsed low during ACCESS of a write -> mem_control_write=0 same cycle, no ack, and all outputs at reset values.
REQ-033 The bench SHALL cover: req0 still high the cycle after ack0 -> a second transaction starts and a second ack0 follows 3 cycles after the first.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Port 1 wins when it is the only requester or it has been starved long enough.
  function automatic logic pick_port1(input logic req0, input logic req1, input logic starved);
    return req1 && (!req0 || starved);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: port 0 (pipeline)
// has priority, port 1 (loader/debug) is forced through after MAX_WAIT losses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_MSB = 31,
  parameter int unsigned ADDR_MSB = 7,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0,
  input  logic                we0,
  input  logic [ADDR_MSB:0]   addr0,
  input  logic [DATA_MSB:0]   wdata0,
  output logic                ack0,
  output logic [DATA_MSB:0]   rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDR_MSB:0]   addr1,
  input  logic [DATA_MSB:0]   wdata1,
  output logic                ack1,
  output logic [DATA_MSB:0]   rdata1,
  output logic [ADDR_MSB:0]   mem_address,
  output logic [DATA_MSB:0]   mem_write_data,
  output logic                mem_control_write,
  input  logic [DATA_MSB:0]   mem_read_data
);

  localparam int unsigned WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt;
  logic           grant_c;
  logic           grant1_c;
  logic           port_q;
  logic           wr_q;

  // Next state and grant decision; arbitration happens only in IDLE.
  always_comb begin
    state_d  = state_q;
    grant_c  = 1'b0;
    grant1_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_c  = 1'b1;
          grant1_c = pick_port1(req0, req1, wait_cnt == WAIT_SAT);
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the granted request; write strobe is high only for the ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q            <= PORT0;
      wr_q              <= 1'b0;
      mem_address       <= '0;
      mem_write_data    <= '0;
      mem_control_write <= 1'b0;
    end else if (grant_c) begin
      port_q            <= grant1_c;
      wr_q              <= grant1_c ? we1 : we0;
      mem_address       <= grant1_c ? addr1 : addr0;
      mem_write_data    <= grant1_c ? wdata1 : wdata0;
      mem_control_write <= grant1_c ? we1 : we0;
    end else begin
      mem_control_write <= 1'b0;
    end
  end

  // Capture read data at the end of ACCESS and pulse the granted ack in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= (state_q == ACCESS) && (port_q == PORT0);
      ack1 <= (state_q == ACCESS) && (port_q == PORT1);
      if ((state_q == ACCESS) && !wr_q) begin
        if (port_q == PORT1) rdata1 <= mem_read_data;
        else                 rdata0 <= mem_read_data;
      end
    end
  end

  // Count how many arbitrations port 1 has lost in a row, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (!req1 || grant1_c)          wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)  wait_cnt <= wait_cnt + WCW'(1);
    end
  end

endmodule
